// File: rtl/ram_sdp_clr.sv
// ram_sdp_clr: simple-dual-port synchronous RAM with a hardware clear sequencer.
//
// One write port and one read port share a single rising-edge clock. Writes
// are byte-lane masked. Reads are registered, with one-cycle latency, and
// flagged by rd_valid. After reset, or when clear is requested, a sequencer
// takes ownership of the array and writes zero to every word in turn. While
// it does so, busy is high and user requests are discarded and flagged on
// drop_err.
//
// Parameters:
//   DATA_W    - word width in bits; must be a multiple of 8
//   ADDR_W    - address width; DEPTH = 2**ADDR_W words
//   READ_MODE - same-address read/write collision:
//               0 = read-first (returns the old word)
//               1 = write-first (returns the merged new word)
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous, active-high reset
//   clear    in   request to zero the array (honoured in RUN only)
//   wr_en    in   write request
//   wr_addr  in   write address
//   wr_data  in   write data
//   wr_be    in   byte-lane enables; bit i covers wr_data[8i+7:8i]
//   rd_en    in   read request
//   rd_addr  in   read address
//   rd_data  out  registered read data; holds its value when no read occurs
//   rd_valid out  high for one cycle when rd_data was updated by a read
//   busy     out  high while the clear sequencer owns the array
//   drop_err out  one-cycle pulse when a request was discarded
//
// Handshake: there is no back-pressure. A request is accepted on any edge
// where busy=0 and clear=0. Otherwise it is discarded, and drop_err is high
// after that edge. rd_valid is high after the edge that accepted a read.
//
// The FSM state is held in the signal 'state' (ST_CLEAR / ST_RUN), so that
// checkers can bind to it directly.

module ram_sdp_clr #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 3,
    parameter int READ_MODE = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic                busy,
    output logic                drop_err
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    // The array has no reset, so synthesis can map it to block RAM.
    // The only source of the zero guarantee is the sweep below.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [0:0]        state;
    logic [ADDR_W-1:0] clr_ptr;

    // The single write port is shared by the clear sweep and the user.
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [NB-1:0]     mem_be;

    logic              accept;   // in RUN and no clear request this cycle
    logic              rd_fire;
    logic [DATA_W-1:0] rd_word;

    assign busy = (state == ST_CLEAR);

    // Write-port arbitration. Nothing is written on a reset edge. The
    // sweep always writes a full zero word.
    always_comb begin
        accept    = (state == ST_RUN) && !clear;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (!reset) begin
            if (state == ST_CLEAR) begin
                mem_we    = 1'b1;
                mem_addr  = clr_ptr;
                mem_wdata = '0;
                mem_be    = '1;
            end else if (accept && wr_en) begin
                // wr_be == 0 still takes this path and simply changes no lane.
                mem_we    = 1'b1;
                mem_addr  = wr_addr;
                mem_wdata = wr_data;
                mem_be    = wr_be;
            end
        end
    end

    // Read data selection. In read-first mode, the old word is used as is.
    // In write-first mode, a colliding write's enabled lanes are forwarded
    // over the stored word, so the read returns the merged result.
    always_comb begin
        rd_fire = !reset && accept && rd_en;
        rd_word = mem[rd_addr];
        if (READ_MODE != 0 && mem_we && (mem_addr == rd_addr)) begin
            for (int i = 0; i < NB; i++) begin
                if (mem_be[i]) begin
                    rd_word[8*i +: 8] = mem_wdata[8*i +: 8];
                end
            end
        end
    end

    // Array write. This block has no reset branch. mem_we is already low
    // on reset edges.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (mem_be[i]) begin
                    mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    // Control FSM and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_CLEAR;
            clr_ptr  <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            drop_err <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    // The sweep cannot be restarted: clear is ignored here.
                    rd_valid <= 1'b0;
                    drop_err <= wr_en || rd_en;
                    clr_ptr  <= clr_ptr + 1'b1;
                    if (clr_ptr == LAST_ADDR) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (clear) begin
                        state    <= ST_CLEAR;
                        clr_ptr  <= '0;
                        rd_valid <= 1'b0;
                        drop_err <= wr_en || rd_en;
                    end else begin
                        drop_err <= 1'b0;
                        rd_valid <= rd_fire;
                        if (rd_fire) begin
                            rd_data <= rd_word;
                        end
                    end
                end
                default: begin
                    state    <= ST_CLEAR;
                    clr_ptr  <= '0;
                    rd_valid <= 1'b0;
                    drop_err <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ram_sdp_clr.md
Name: ram_sdp_clr

Overview:
- Parametrised simple-dual-port synchronous RAM: one write port, one read port, one clock.
- Successor to the 8x8 single-port RAM. Adds the following:
  - generic width and depth;
  - byte-lane write enables;
  - a registered read with a valid flag;
  - selectable read-during-write behaviour;
  - a hardware clear sequencer that zeroes the array after reset or on demand.
- Used as scratch storage by the lab datapaths.

Parameters:
DATA_W, 16, data word width in bits. Must be a multiple of 8.
ADDR_W, 3, address width. DEPTH = 2**ADDR_W words; the full address range is valid.
READ_MODE, 0, same-address read/write collision: 0 = read-first (returns old data), 1 = write-first (returns new merged data).

Ports:
clk  in  1  rising-edge clock.
reset  in  1  synchronous, active-high reset.
clear  in  1  request to zero the whole array; sampled in RUN only.
wr_en  in  1  write request.
wr_addr  in  ADDR_W  write address.
wr_data  in  DATA_W  write data.
wr_be  in  DATA_W/8  byte-lane enables; bit i covers wr_data[8i+7:8i].
rd_en  in  1  read request.
rd_addr  in  ADDR_W  read address.
rd_data  out  DATA_W  registered read data.
rd_valid  out  1  high for one cycle when rd_data is updated by a read.
busy  out  1  high while the clear sequencer owns the array.
drop_err  out  1  one-cycle pulse when a request is discarded.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, on port reset. All state changes occur on the rising edge of clk.
- FSM states:
  - CLEAR: busy=1, sequencer owns the array.
  - RUN: busy=0, normal read/write operation.
- Reset, at any edge where reset=1, from any state including mid-CLEAR:
  - state=CLEAR, clr_ptr=0, busy=1;
  - rd_data=0, rd_valid=0, drop_err=0;
  - the array is not written on reset edges.
- CLEAR, each edge with reset=0:
  - writes 0 to mem[clr_ptr], then increments clr_ptr;
  - on the edge that writes mem[DEPTH-1], moves to RUN, so busy falls after that edge;
  - net effect: busy stays high for exactly DEPTH cycles after reset is released;
  - clear=1 is ignored (no restart);
  - wr_en and rd_en are ignored: no array access, rd_valid=0;
  - drop_err=1 after any edge where wr_en or rd_en is high.
- RUN, with clear=1 at an edge:
  - moves to CLEAR with clr_ptr=0;
  - any write or read in the same cycle is dropped and drop_err=1.
- RUN write: on an edge with wr_en=1, byte lane i of mem[wr_addr] takes wr_data lane i if wr_be[i]=1; other lanes are kept. wr_be=0 is a legal no-op with no error.
- RUN read: on an edge with rd_en=1, rd_data takes mem[rd_addr] (one-cycle latency) and rd_valid=1. With rd_en=0, rd_valid=0 and rd_data holds its last value.
- Same-cycle read and write to the same address:
  - READ_MODE=0: rd_data is the pre-write word.
  - READ_MODE=1: rd_data is the merged post-write word (new lanes where wr_be=1, old lanes elsewhere).
  - Different addresses: both operations complete independently.
- Defaults: drop_err=0 on every edge not listed above.
- Array implementation: no reset on the array itself, which allows inference as block RAM. The zero guarantee comes only from the sequencer.

Test Plan:
- Reset then release (DATA_W=16, ADDR_W=3): busy=1 for exactly 8 cycles after release, then 0. Reading addresses 0..7 then returns 16'h0000 each time, with rd_valid high one cycle after each rd_en.
- Write 16'h1111*(a+1) to each address a=0..7 with wr_be=2'b11, then read back: read addresses 0..7 -> 16'h1111..16'h8888 in order, 1-cycle latency; rd_data holds 16'h8888 once rd_en drops.
- Byte-lane merge: mem[3]=16'hABCD, then write 16'h1234 with wr_be=2'b01 -> read 3 returns 16'hAB34. With wr_be=2'b10 instead -> 16'h12CD.
- Collision: mem[5]=16'h00FF, then same-cycle write 16'hBEEF (wr_be=2'b11) and read at address 5:
  - READ_MODE=0 -> rd_data=16'h00FF, and a later read -> 16'hBEEF;
  - READ_MODE=1 -> rd_data=16'hBEEF.
- Runtime clear: fill the array with 16'h5A5A, then pulse clear together with wr_en (address 2, 16'h7777):
  - drop_err=1 for one cycle, busy high 8 cycles;
  - rd_en during busy -> rd_valid=0 and drop_err=1;
  - afterwards all reads return 16'h0000, including address 2.
- Reset mid-CLEAR: assert reset after 4 sweep cycles for 2 cycles -> busy stays high, and then exactly 8 further cycles after release; all addresses read 0.
